// File: rtl/register_error_monitor_if.sv
// IO bus request/acknowledge bundle between the bus master and one subsystem.
// The tri-state return paths (data_in, nFault) are plain ports on the subsystem.
interface register_error_monitor_if #(
  parameter int ADDR_W = 8
);
  logic              handshake_1;
  logic              handshake_2;
  logic              RW;
  logic              register_address_valid;
  logic [ADDR_W-1:0] reg_address;
  logic [31:0]       data_out;

  modport master (
    output handshake_1, RW, register_address_valid, reg_address, data_out,
    input  handshake_2
  );

  modport slave (
    input  handshake_1, RW, register_address_valid, reg_address, data_out,
    output handshake_2
  );
endinterface

// File: rtl/register_error_monitor.sv
// Answers accesses to the unassigned register window so the bus never hangs,
// flags them on nFault and keeps a saturating count plus last-error capture.
module register_error_monitor #(
  parameter int                ADDR_W        = 8,
  parameter logic [ADDR_W-1:0] FIRST_ILLEGAL = 8'd200,
  parameter logic [ADDR_W-1:0] LAST_REGISTER = 8'd255,
  parameter logic [ADDR_W-1:0] DIAG_BASE     = 8'd196,
  parameter int                CNT_W         = 16,
  parameter bit                STICKY_FAULT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  register_error_monitor_if.slave  bus,
  output wire  [31:0]              data_in,
  output wire                      nFault
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    XFER        = 3'd1,
    DATA_ACK    = 3'd2,
    STATUS_WAIT = 3'd3,
    STATUS_ACK  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   ILL_LO    = {1'b0, FIRST_ILLEGAL};
  localparam logic [ADDR_W:0]   ILL_HI    = {1'b0, LAST_REGISTER};
  localparam logic [ADDR_W:0]   DIAG_LO   = {1'b0, DIAG_BASE};
  localparam logic [ADDR_W:0]   DIAG_HI   = {1'b0, DIAG_BASE} + (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] DIAG_CNT  = DIAG_BASE;
  localparam logic [ADDR_W-1:0] DIAG_LAST = DIAG_BASE + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DIAG_CTRL = DIAG_BASE + ADDR_W'(2);

  // The diagnostic block must sit entirely below the illegal window.
  generate
    if (int'(DIAG_BASE) + 2 >= int'(FIRST_ILLEGAL)) begin : g_bad_diag_base
      $error("register_error_monitor: DIAG_BASE+2 overlaps the illegal window");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $error("register_error_monitor: CNT_W must be 1..32");
    end
  endgenerate

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic              rw_r;
  logic              illegal_r;
  logic              hs2_r;
  logic              drive_r;
  logic              fault_r;
  logic [31:0]       word_r;
  logic [CNT_W-1:0]  err_count_r;
  logic [ADDR_W-1:0] last_addr_r;
  logic              last_rw_r;
  logic              sticky_flag_r;

  logic [ADDR_W:0]   addr_x_s;
  logic              illegal_s;
  logic              sel_s;
  logic [31:0]       rd_word_s;
  logic              fault_on_s;

  // Only bits 2:0 of a control write carry meaning.
  wire unused_data_s = &{1'b0, bus.data_out[31:3]};

  // Address decode; zero-extended so the window compare never folds to a constant.
  always_comb begin
    addr_x_s  = {1'b0, bus.reg_address};
    illegal_s = (addr_x_s >= ILL_LO) && (addr_x_s <= ILL_HI);
    sel_s     = bus.register_address_valid &&
                (illegal_s || ((addr_x_s >= DIAG_LO) && (addr_x_s <= DIAG_HI)));
  end

  // Response word for the latched address, sampled in XFER.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    if (illegal_r) begin
      rd_word_s = 32'h5555_5555;
    end else if (addr_r == DIAG_CNT) begin
      rd_word_s = 32'(err_count_r);
    end else if (addr_r == DIAG_LAST) begin
      rd_word_s = {last_rw_r, 15'b0, 16'(last_addr_r)};
    end else begin
      rd_word_s = {29'b0, sticky_flag_r, 2'b0};
    end
  end

  // Transaction FSM with registered bus outputs and the error records.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      addr_r        <= {ADDR_W{1'b0}};
      rw_r          <= 1'b0;
      illegal_r     <= 1'b0;
      hs2_r         <= 1'b0;
      drive_r       <= 1'b0;
      fault_r       <= 1'b0;
      word_r        <= 32'h0000_0000;
      err_count_r   <= {CNT_W{1'b0}};
      last_addr_r   <= {ADDR_W{1'b0}};
      last_rw_r     <= 1'b0;
      sticky_flag_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.handshake_1 && sel_s) begin
            state_r   <= XFER;
            addr_r    <= bus.reg_address;
            rw_r      <= bus.RW;
            illegal_r <= illegal_s;
            fault_r   <= illegal_s;
          end
        end
        XFER: begin
          state_r <= DATA_ACK;
          hs2_r   <= 1'b1;
          drive_r <= rw_r;
          word_r  <= rd_word_s;
          if (illegal_r) begin
            if (err_count_r != {CNT_W{1'b1}}) begin
              err_count_r <= err_count_r + CNT_W'(1);
            end
            last_addr_r   <= addr_r;
            last_rw_r     <= rw_r;
            sticky_flag_r <= 1'b1;
          end else if (!rw_r && (addr_r == DIAG_CTRL)) begin
            if (bus.data_out[0]) begin
              err_count_r <= {CNT_W{1'b0}};
            end
            if (bus.data_out[1]) begin
              sticky_flag_r <= 1'b0;
            end
            if (bus.data_out[2]) begin
              last_addr_r <= {ADDR_W{1'b0}};
              last_rw_r   <= 1'b0;
            end
          end
        end
        DATA_ACK: begin
          if (!bus.handshake_1) begin
            state_r <= STATUS_WAIT;
            hs2_r   <= 1'b0;
            drive_r <= 1'b0;
          end
        end
        STATUS_WAIT: begin
          if (bus.handshake_1) begin
            state_r <= STATUS_ACK;
            hs2_r   <= 1'b1;
            drive_r <= 1'b1;
            word_r  <= illegal_r ? 32'hAAAA_AAAA : 32'h0000_0000;
          end
        end
        STATUS_ACK: begin
          if (!bus.handshake_1) begin
            state_r <= IDLE;
            hs2_r   <= 1'b0;
            drive_r <= 1'b0;
            fault_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          hs2_r   <= 1'b0;
          drive_r <= 1'b0;
          fault_r <= 1'b0;
        end
      endcase
    end
  end

  // Fault source depends on whether the fault is held until software clears it.
  always_comb begin
    if (STICKY_FAULT) begin
      fault_on_s = sticky_flag_r;
    end else begin
      fault_on_s = fault_r;
    end
  end

  assign bus.handshake_2 = hs2_r;
  assign data_in         = drive_r ? word_r : 32'bz;
  assign nFault          = fault_on_s ? 1'b0 : 1'bz;

endmodule
